// File: rtl/counting_seq_pkg.sv
// Shared state encoding for the 1+2+3+ run detector.
// The encoding is fixed at two bits: IDLE=0, ONE=1, TWO=2, THREE=3.
package counting_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2,
    THREE = 2'd3
  } state_e;

  localparam logic [1:0] SYM_BREAK = 2'd0;
  localparam logic [1:0] SYM_ONE   = 2'd1;
  localparam logic [1:0] SYM_TWO   = 2'd2;
  localparam logic [1:0] SYM_THREE = 2'd3;

endpackage

// File: rtl/counting_seq_if.sv
// Symbol bus watched by counting_seq: the symbol stream in, the run-complete flag out.
interface counting_seq_if;
  logic [1:0] num;
  logic       ans;

  modport master (output num, input ans);
  modport slave  (input num, output ans);
endinterface

// File: rtl/counting_seq.sv
// Moore FSM flagging symbol streams that end in a 1+ 2+ 3+ run.
// ans is held in its own flop, loaded with the decode of the next state.
module counting_seq
  import counting_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  counting_seq_if.slave bus
);

  state_e state_r;
  state_e next_s;
  logic   ans_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state function; a 1 starts a new run from any state
  always_comb begin
    next_s = IDLE;
    if (bus.num == SYM_ONE) begin
      next_s = ONE;
    end else begin
      case (state_r)
        ONE: begin
          if (bus.num == SYM_TWO) begin
            next_s = TWO;
          end else begin
            next_s = IDLE;
          end
        end
        TWO: begin
          if (bus.num == SYM_TWO) begin
            next_s = TWO;
          end else if (bus.num == SYM_THREE) begin
            next_s = THREE;
          end else begin
            next_s = IDLE;
          end
        end
        THREE: begin
          if (bus.num == SYM_THREE) begin
            next_s = THREE;
          end else begin
            next_s = IDLE;
          end
        end
        default: begin
          next_s = IDLE;
        end
      endcase
    end
  end

  // Output flop mirrors (state_r == THREE) without a path from num
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ans_r <= 1'b0;
    end else begin
      ans_r <= (next_s == THREE);
    end
  end

  assign bus.ans = ans_r;

endmodule

// File: tb/tb_counting_seq.sv
// Randomized and directed bench for counting_seq; the reference model scans
// the accepted symbol history backwards for a trailing 1+ 2+ 3+ run.
module tb_counting_seq;

  logic clk;
  logic rst_n;
  int   err_cnt;
  int   chk_cnt;
  logic [1:0] hist[$];

  counting_seq_if bus ();

  counting_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: ans=%0b expected=%0b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Does the history end in at least one 1, then one 2, then one 3?
  function automatic logic model_ans();
    int i  = hist.size() - 1;
    int n3 = 0;
    int n2 = 0;
    int n1 = 0;
    while (i >= 0 && hist[i] == 2'd3) begin n3++; i--; end
    while (i >= 0 && hist[i] == 2'd2) begin n2++; i--; end
    while (i >= 0 && hist[i] == 2'd1) begin n1++; i--; end
    return (n3 > 0) && (n2 > 0) && (n1 > 0);
  endfunction

  task automatic step(input logic [1:0] sym, input string tag);
    bus.num = sym;
    @(posedge clk);
    #1;
    hist.push_back(sym);
    check(tag, bus.ans, model_ans());
  endtask

  task automatic step_exp(input logic [1:0] sym, input logic exp, input string tag);
    bus.num = sym;
    @(posedge clk);
    #1;
    hist.push_back(sym);
    check(tag, bus.ans, exp);
    check({tag, "_model"}, bus.ans, model_ans());
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    hist.delete();
    bus.num = 2'd0;
    @(posedge clk);
    #1;
    check("rst", bus.ans, 1'b0);
    rst_n = 1'b1;
  endtask

  logic [1:0] seq2[16] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1, 2'd2, 2'd1,
                           2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1};
  logic       exp2[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    rst_n   = 1'b0;
    bus.num = 2'd3;
    #2;
    check("rst_async", bus.ans, 1'b0);

    // 1: reset held with num=3
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", bus.ans, 1'b0);
    end
    rst_n = 1'b1;
    step_exp(2'd1, 1'b0, "rel_1");
    step_exp(2'd2, 1'b0, "rel_2");
    step_exp(2'd3, 1'b1, "rel_3");

    // 2: directed sequence
    apply_reset();
    for (int i = 0; i < 16; i++) step_exp(seq2[i], exp2[i], "seq2");

    // 3: broken runs
    apply_reset();
    step_exp(2'd1, 1'b0, "brk_a"); step_exp(2'd3, 1'b0, "brk_a");
    step_exp(2'd2, 1'b0, "brk_a"); step_exp(2'd3, 1'b0, "brk_a");
    apply_reset();
    step_exp(2'd2, 1'b0, "brk_b"); step_exp(2'd3, 1'b0, "brk_b");
    apply_reset();
    step_exp(2'd1, 1'b0, "brk_c"); step_exp(2'd2, 1'b0, "brk_c");
    step_exp(2'd0, 1'b0, "brk_c"); step_exp(2'd3, 1'b0, "brk_c");

    // 4: exit from THREE
    apply_reset();
    step_exp(2'd1, 1'b0, "exit"); step_exp(2'd2, 1'b0, "exit");
    step_exp(2'd3, 1'b1, "exit"); step_exp(2'd2, 1'b0, "exit");
    step_exp(2'd3, 1'b0, "exit");

    // 5: asynchronous reset between edges
    step_exp(2'd1, 1'b0, "arst"); step_exp(2'd2, 1'b0, "arst");
    step_exp(2'd3, 1'b1, "arst");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_drop", bus.ans, 1'b0);
    hist.delete();
    #1;
    rst_n = 1'b1;
    step_exp(2'd3, 1'b0, "arst_after");

    // 6: long runs
    apply_reset();
    for (int i = 0; i < 20; i++) step_exp(2'd1, 1'b0, "long_1");
    for (int i = 0; i < 20; i++) step_exp(2'd2, 1'b0, "long_2");
    for (int i = 0; i < 20; i++) step_exp(2'd3, 1'b1, "long_3");

    // Random runs of symbols with occasional mid-stream resets
    apply_reset();
    for (int r = 0; r < 200; r++) begin
      logic [1:0] sym;
      int         len;
      if ($urandom_range(0, 9) == 0) sym = 2'd0;
      else sym = 2'($urandom_range(1, 3));
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) step(sym, "rand");
      if ($urandom_range(0, 39) == 0) apply_reset();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/counting_seq.md
# counting_seq

Synchronous sequence detector that watches a 2-bit symbol stream and flags completion of a run of the form 1⁺ 2⁺ 3⁺. One symbol is consumed per clock edge. `ans` is high in every cycle in which the symbols accepted so far end in a valid 1⁺2⁺3⁺ run. The block is a small Moore FSM and is intended as a leaf pattern monitor on a symbol bus.

## Interface
- No parameters.
- `clk`  input  1  rising-edge clock; `num` is sampled on each rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `num`  input  2  input symbol. Values 1, 2 and 3 are pattern symbols; 0 is a break symbol.
- `ans`  output  1  high when the FSM is in state THREE.

Reset is asynchronous and active-low. All state is clocked by `clk`.

## Operation
States:
- IDLE: no partial match.
- ONE: one or more 1s seen.
- TWO: 1⁺ followed by 2⁺.
- THREE: 1⁺2⁺ followed by 3⁺.

Transitions, evaluated on each rising edge using `num`:
- `num`=1 goes to ONE from any state. This includes THREE, so a new run can begin immediately after a completed one.
- ONE: 2 goes to TWO. 3 goes to IDLE. 0 goes to IDLE.
- TWO: 2 stays in TWO. 3 goes to THREE. 0 goes to IDLE.
- THREE: 3 stays in THREE. 2 goes to IDLE. 0 goes to IDLE.
- IDLE: 2, 3 and 0 all stay in IDLE.

Output:
- `ans` = (state == THREE). It is a pure Moore output with no combinational path from `num`.
- `ans` stays high for every consecutive 3 after the first 3 of a valid run.

## Timing
- Latency: the symbol sampled at edge k is reflected in `ans` after edge k, throughout cycle k+1.
- Reset: while `rst_n`=0, state is IDLE and `ans`=0, immediately and independent of `clk`.
- Reset release: the first rising edge with `rst_n`=1 samples `num` normally.
- Reset asserted mid-run: the partial match is discarded and `ans` drops at once.
- No counters and no overflow. Runs of any length, whether 1s, 2s or 3s, keep their state.
- State encoding: 2-bit register, IDLE=0, ONE=1, TWO=2, THREE=3.

## Structure
- Put the state encoding constants in a shared package, `counting_pkg`: IDLE, ONE, TWO, THREE.
- The design is a single module with no sub-modules:
  - one asynchronous-reset state register;
  - one combinational next-state function;
  - `ans` decoded from the state.

## Test plan
1. Reset: hold `rst_n`=0 and apply `num`=3 for 3 cycles.
   -> `ans`=0 throughout.
   Release reset, then apply 1,2,3.
   -> `ans`=1 after the third edge.
2. Sequence 1,1,2,3,3,1,2,1,1,1,2,2,3,3,3,1, one symbol per edge.
   -> `ans` after each edge is 0,0,0,1,1,0,0,0,0,0,0,0,1,1,1,0.
3. Broken runs:
   - 1,3,2,3 -> `ans` stays 0.
   - 2,3 from IDLE -> `ans` stays 0.
   - 1,2,0,3 -> `ans` stays 0.
4. Exit from THREE:
   - 1,2,3 then 2 -> `ans` goes 1 then 0, state IDLE.
   - Follow with 3 -> `ans` stays 0.
5. Asynchronous reset: after 1,2,3 with `ans`=1, pulse `rst_n` low between clock edges.
   -> `ans` falls before the next rising edge.
   After release, apply 3.
   -> `ans` stays 0.
6. Long runs: apply 1×20, 2×20, 3×20.
   -> `ans` rises on the first 3 and stays 1 for all 20 cycles.
